// File: rtl/bus1_arbiter_pkg.sv
// Shared bus-1 widths, C1 command codes and arbiter state encoding.
// C1_RESPONSE reuses the WRITE32 code: only the cache drives it, and only while the arbiter has released C1.
package bus1_arbiter_pkg;

    localparam int A1_W = 14;
    localparam int D1_W = 16;
    localparam int C1_W = 3;

    localparam logic [C1_W-1:0] C1_NOP             = 3'd0;
    localparam logic [C1_W-1:0] C1_READ8           = 3'd1;
    localparam logic [C1_W-1:0] C1_READ16          = 3'd2;
    localparam logic [C1_W-1:0] C1_READ32          = 3'd3;
    localparam logic [C1_W-1:0] C1_INVALIDATE_LINE = 3'd4;
    localparam logic [C1_W-1:0] C1_WRITE8          = 3'd5;
    localparam logic [C1_W-1:0] C1_WRITE16         = 3'd6;
    localparam logic [C1_W-1:0] C1_WRITE32         = 3'd7;
    localparam logic [C1_W-1:0] C1_RESPONSE        = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR1,
        S_ADDR2,
        S_WAIT,
        S_RESP2,
        S_DONE
    } bus1_arb_state_t;

    function automatic logic isWrite(input logic [C1_W-1:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

endpackage

// File: rtl/bus1_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module bus1_arbiter_rr_pick #(
    parameter int N_MASTERS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [PTR_W-1:0]     idx_o,
    output logic                 valid_o
);

    logic found;

    always_comb begin
        int j;
        j      = 0;
        found  = 1'b0;
        gnt_o  = '0;
        idx_o  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            j = (int'(ptr_i) + i) % N_MASTERS;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PTR_W'(j);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/bus1_arbiter.sv
// Round-robin owner of the CPU-side bus 1: sequences command/address halves, releases the bus,
// then waits for the cache response (with timeout) and returns read data to the owning master.
module bus1_arbiter
    import bus1_arbiter_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int ADDR1_BUS_SIZE = A1_W,
    parameter int DATA1_BUS_SIZE = D1_W,
    parameter int CTR1_BUS_SIZE  = C1_W,
    parameter int TIMEOUT        = 255
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [N_MASTERS-1:0]                  M_REQ,
    input  logic [N_MASTERS*CTR1_BUS_SIZE-1:0]    M_CMD,
    input  logic [N_MASTERS*2*ADDR1_BUS_SIZE-1:0] M_ADDR,
    input  logic [N_MASTERS*2*DATA1_BUS_SIZE-1:0] M_WDATA,
    output logic [N_MASTERS-1:0]                  M_GNT,
    output logic [N_MASTERS-1:0]                  M_DONE,
    output logic                                  M_ERR,
    output logic [2*DATA1_BUS_SIZE-1:0]           M_RDATA,
    inout  wire  [ADDR1_BUS_SIZE-1:0]             A1_WIRE,
    inout  wire  [DATA1_BUS_SIZE-1:0]             D1_WIRE,
    inout  wire  [CTR1_BUS_SIZE-1:0]              C1_WIRE
);

    localparam int AW    = ADDR1_BUS_SIZE;
    localparam int DW    = DATA1_BUS_SIZE;
    localparam int CW    = CTR1_BUS_SIZE;
    localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    bus1_arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [N_MASTERS-1:0]   ownerOh_q, ownerOh_d;
    logic [CW-1:0]          cmd_q, cmd_d;
    logic [2*AW-1:0]        addr_q, addr_d;
    logic [2*DW-1:0]        wdata_q, wdata_d;
    logic [2*DW-1:0]        rdata_q, rdata_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic [N_MASTERS-1:0]   pickGnt;
    logic [PTR_W-1:0]       pickIdx;
    logic                   pickValid;

    logic                   a1En, d1En, c1En;
    logic [AW-1:0]          a1Out;
    logic [DW-1:0]          d1Out;
    logic [CW-1:0]          c1Out;

    bus1_arbiter_rr_pick #(
        .N_MASTERS (N_MASTERS),
        .PTR_W     (PTR_W)
    ) u_pick (
        .req_i   (M_REQ),
        .ptr_i   (ptr_q),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            ownerOh_q <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            ownerOh_q <= ownerOh_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        ownerOh_d = ownerOh_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (pickValid) begin
                    owner_d   = pickIdx;
                    ownerOh_d = pickGnt;
                    cmd_d     = M_CMD[pickIdx*CW +: CW];
                    addr_d    = M_ADDR[pickIdx*2*AW +: 2*AW];
                    wdata_d   = M_WDATA[pickIdx*2*DW +: 2*DW];
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_ADDR1;
                end
            end
            S_ADDR1: state_d = S_ADDR2;
            S_ADDR2: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (C1_WIRE == C1_RESPONSE) begin
                    rdata_d[2*DW-1:DW] = D1_WIRE;
                    state_d = (cmd_q == C1_READ32) ? S_RESP2 : S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RESP2: begin
                rdata_d[DW-1:0] = D1_WIRE;
                state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d   = (owner_q == PTR_W'(N_MASTERS - 1)) ? '0 : owner_q + PTR_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drivers are decoded from the registered state so an async reset releases the bus at once.
    always_comb begin
        a1En  = 1'b0;
        d1En  = 1'b0;
        c1En  = 1'b0;
        a1Out = '0;
        d1Out = '0;
        c1Out = cmd_q;
        case (state_q)
            S_ADDR1: begin
                c1En  = 1'b1;
                a1En  = 1'b1;
                a1Out = addr_q[2*AW-1:AW];
                d1En  = isWrite(cmd_q);
                d1Out = wdata_q[2*DW-1:DW];
            end
            S_ADDR2: begin
                c1En  = 1'b1;
                a1En  = 1'b1;
                a1Out = addr_q[AW-1:0];
                d1En  = (cmd_q == C1_WRITE32);
                d1Out = wdata_q[DW-1:0];
            end
            default: ;
        endcase
    end

    assign A1_WIRE = a1En ? a1Out : 'z;
    assign D1_WIRE = d1En ? d1Out : 'z;
    assign C1_WIRE = c1En ? c1Out : 'z;

    assign M_GNT   = (state_q != S_IDLE) ? ownerOh_q : '0;
    assign M_DONE  = (state_q == S_DONE) ? ownerOh_q : '0;
    assign M_ERR   = (state_q == S_DONE) && err_q;
    assign M_RDATA = rdata_q;

endmodule

// File: tb/tb_bus1_arbiter.sv
// Directed bench for bus1_arbiter: a two-master setup with a scripted cache driving the shared bus.
module tb_bus1_arbiter;
    import bus1_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam int CW = 3;
    localparam int TO = 255;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic [N-1:0]      M_REQ = '0;
    logic [N*CW-1:0]   M_CMD = '0;
    logic [N*2*AW-1:0] M_ADDR = '0;
    logic [N*2*DW-1:0] M_WDATA = '0;
    logic [N-1:0]      M_GNT;
    logic [N-1:0]      M_DONE;
    logic              M_ERR;
    logic [2*DW-1:0]   M_RDATA;
    wire  [AW-1:0]     A1_WIRE;
    wire  [DW-1:0]     D1_WIRE;
    wire  [CW-1:0]     C1_WIRE;

    logic              cacheC1Drive = 1'b0;
    logic [CW-1:0]     cacheC1Val = '0;
    logic              cacheD1Drive = 1'b0;
    logic [DW-1:0]     cacheD1Val = '0;

    int compared = 0;
    int mismatched = 0;

    assign C1_WIRE = cacheC1Drive ? cacheC1Val : 'z;
    assign D1_WIRE = cacheD1Drive ? cacheD1Val : 'z;

    wire a1Float = (A1_WIRE === {AW{1'bz}});
    wire d1Float = (D1_WIRE === {DW{1'bz}});
    wire c1Float = (C1_WIRE === {CW{1'bz}});

    bus1_arbiter #(
        .N_MASTERS      (N),
        .ADDR1_BUS_SIZE (AW),
        .DATA1_BUS_SIZE (DW),
        .CTR1_BUS_SIZE  (CW),
        .TIMEOUT        (TO)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .M_REQ   (M_REQ),
        .M_CMD   (M_CMD),
        .M_ADDR  (M_ADDR),
        .M_WDATA (M_WDATA),
        .M_GNT   (M_GNT),
        .M_DONE  (M_DONE),
        .M_ERR   (M_ERR),
        .M_RDATA (M_RDATA),
        .A1_WIRE (A1_WIRE),
        .D1_WIRE (D1_WIRE),
        .C1_WIRE (C1_WIRE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input logic [CW-1:0] cmd,
                                 input logic [2*AW-1:0] addr, input logic [2*DW-1:0] wdata);
        M_CMD[m*CW +: CW]         = cmd;
        M_ADDR[m*2*AW +: 2*AW]    = addr;
        M_WDATA[m*2*DW +: 2*DW]   = wdata;
    endtask

    task automatic cacheRespond(input logic [DW-1:0] beat, input logic withData);
        cacheC1Drive = 1'b1;
        cacheC1Val   = C1_RESPONSE;
        cacheD1Drive = withData;
        cacheD1Val   = beat;
    endtask

    task automatic cacheRelease();
        cacheC1Drive = 1'b0;
        cacheD1Drive = 1'b0;
    endtask

    // One zero-wait READ8 from IDLE; reqAfter is what the masters request once DONE is seen.
    task automatic serveRead8(input int owner, input logic [DW-1:0] beat, input logic [N-1:0] reqAfter);
        logic [N-1:0] oh;
        oh = N'(1) << owner;
        tick();
        checkOutput("serve_gnt_addr1", 64'(M_GNT), 64'(oh));
        tick();
        tick();
        cacheRespond(beat, 1'b1);
        tick();
        checkOutput("serve_done", 64'(M_DONE), 64'(oh));
        checkOutput("serve_rdata", 64'(M_RDATA), 64'({beat, 16'h0000}));
        checkOutput("serve_err", 64'(M_ERR), 64'd0);
        cacheRelease();
        M_REQ = reqAfter;
        tick();
        checkOutput("serve_idle_gnt", 64'(M_GNT), 64'd0);
    endtask

    initial begin
        @(negedge CLK);
        checkOutput("rst_gnt", 64'(M_GNT), 64'd0);
        checkOutput("rst_done", 64'(M_DONE), 64'd0);
        checkOutput("rst_err", 64'(M_ERR), 64'd0);
        checkOutput("rst_rdata", 64'(M_RDATA), 64'd0);
        checkOutput("rst_a1_z", 64'(a1Float), 64'd1);
        checkOutput("rst_d1_z", 64'(d1Float), 64'd1);
        checkOutput("rst_c1_z", 64'(c1Float), 64'd1);
        RESET = 1'b1;
        tick();

        $display("[TB] simultaneous requests, round robin");
        applyStimulus(0, C1_READ8, 28'h0000010, 32'h0);
        applyStimulus(1, C1_READ8, 28'h0000020, 32'h0);
        M_REQ = 2'b11;
        serveRead8(0, 16'h1111, 2'b10);
        serveRead8(1, 16'h2222, 2'b00);
        M_REQ = 2'b11;
        serveRead8(0, 16'h3333, 2'b11);
        serveRead8(1, 16'h4444, 2'b01);
        serveRead8(0, 16'h5555, 2'b00);

        $display("[TB] single READ8, 3-cycle cache latency");
        applyStimulus(0, C1_READ8, {14'h1, 14'h2}, 32'h0);
        M_REQ = 2'b01;
        tick();
        checkOutput("r8_gnt", 64'(M_GNT), 64'h1);
        checkOutput("r8_c1_addr1", 64'(C1_WIRE), 64'(C1_READ8));
        checkOutput("r8_a1_addr1", 64'(A1_WIRE), 64'h1);
        checkOutput("r8_d1_z_addr1", 64'(d1Float), 64'd1);
        tick();
        checkOutput("r8_a1_addr2", 64'(A1_WIRE), 64'h2);
        checkOutput("r8_c1_addr2", 64'(C1_WIRE), 64'(C1_READ8));
        tick();
        checkOutput("r8_c1_z_wait", 64'(c1Float), 64'd1);
        checkOutput("r8_a1_z_wait", 64'(a1Float), 64'd1);
        tick();
        tick();
        checkOutput("r8_no_early_done", 64'(M_DONE), 64'd0);
        cacheRespond(16'hBEEF, 1'b1);
        tick();
        checkOutput("r8_done", 64'(M_DONE), 64'h1);
        checkOutput("r8_rdata", 64'(M_RDATA), 64'hBEEF0000);
        checkOutput("r8_err", 64'(M_ERR), 64'd0);
        checkOutput("r8_gnt_in_done", 64'(M_GNT), 64'h1);
        cacheRelease();
        M_REQ = 2'b00;
        tick();
        checkOutput("r8_done_pulse", 64'(M_DONE), 64'd0);
        checkOutput("r8_gnt_clear", 64'(M_GNT), 64'd0);

        $display("[TB] WRITE32 data phases");
        applyStimulus(1, C1_WRITE32, {14'h0AB, 14'h0CD}, {16'h1234, 16'h5678});
        M_REQ = 2'b10;
        tick();
        checkOutput("w32_gnt", 64'(M_GNT), 64'h2);
        checkOutput("w32_c1_addr1", 64'(C1_WIRE), 64'(C1_WRITE32));
        checkOutput("w32_d1_addr1", 64'(D1_WIRE), 64'h1234);
        tick();
        checkOutput("w32_d1_addr2", 64'(D1_WIRE), 64'h5678);
        checkOutput("w32_a1_addr2", 64'(A1_WIRE), 64'h0CD);
        tick();
        checkOutput("w32_d1_z_wait", 64'(d1Float), 64'd1);
        checkOutput("w32_c1_z_wait", 64'(c1Float), 64'd1);
        cacheRespond(16'h0, 1'b0);
        tick();
        checkOutput("w32_done", 64'(M_DONE), 64'h2);
        cacheRelease();
        M_REQ = 2'b00;
        tick();
        checkOutput("w32_d1_z_idle", 64'(d1Float), 64'd1);

        $display("[TB] READ32 two response beats");
        applyStimulus(0, C1_READ32, {14'h010, 14'h004}, 32'h0);
        M_REQ = 2'b01;
        tick();
        checkOutput("r32_gnt", 64'(M_GNT), 64'h1);
        tick();
        tick();
        cacheRespond(16'hAAAA, 1'b1);
        tick();
        checkOutput("r32_no_done_resp2", 64'(M_DONE), 64'd0);
        cacheC1Drive = 1'b0;
        cacheD1Val   = 16'h5555;
        tick();
        checkOutput("r32_done", 64'(M_DONE), 64'h1);
        checkOutput("r32_rdata", 64'(M_RDATA), 64'hAAAA5555);
        cacheRelease();
        M_REQ = 2'b00;
        tick();

        $display("[TB] cache timeout");
        applyStimulus(1, C1_READ16, {14'h020, 14'h006}, 32'h0);
        M_REQ = 2'b10;
        tick();
        tick();
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        checkOutput("to_not_yet", 64'(M_DONE), 64'd0);
        tick();
        checkOutput("to_done", 64'(M_DONE), 64'h2);
        checkOutput("to_err", 64'(M_ERR), 64'd1);
        M_REQ = 2'b00;
        tick();
        checkOutput("to_err_clear", 64'(M_ERR), 64'd0);
        applyStimulus(0, C1_READ8, 28'h0000ABC, 32'h0);
        M_REQ = 2'b01;
        serveRead8(0, 16'h7E57, 2'b00);

        $display("[TB] reset during ADDR2");
        applyStimulus(1, C1_WRITE32, {14'h3AA, 14'h155}, {16'hCAFE, 16'hF00D});
        M_REQ = 2'b10;
        tick();
        tick();
        checkOutput("rm_a1_addr2", 64'(A1_WIRE), 64'h155);
        checkOutput("rm_d1_addr2", 64'(D1_WIRE), 64'hF00D);
        RESET = 1'b0;
        #1;
        checkOutput("rm_a1_z", 64'(a1Float), 64'd1);
        checkOutput("rm_d1_z", 64'(d1Float), 64'd1);
        checkOutput("rm_c1_z", 64'(c1Float), 64'd1);
        checkOutput("rm_gnt", 64'(M_GNT), 64'd0);
        checkOutput("rm_done", 64'(M_DONE), 64'd0);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("rm_done_held", 64'(M_DONE), 64'd0);
        RESET = 1'b1;
        tick();
        checkOutput("rm_restart_gnt", 64'(M_GNT), 64'h2);
        checkOutput("rm_restart_c1", 64'(C1_WIRE), 64'(C1_WRITE32));
        checkOutput("rm_restart_a1", 64'(A1_WIRE), 64'h3AA);
        checkOutput("rm_restart_d1", 64'(D1_WIRE), 64'hCAFE);
        tick();
        tick();
        cacheRespond(16'h0, 1'b0);
        tick();
        checkOutput("rm_done_after", 64'(M_DONE), 64'h2);
        cacheRelease();
        M_REQ = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
